fifo_rd_stream: RTL

Read-side drain stage placed directly downstream of the synchronous FIFO. It drives the FIFO's r_en from the FIFO's empty flag and the space left in a small local buffer. It captures fifo data_out, which has one cycle of read latency, and presents it as a valid/ready stream with beat framing (m_last) for the consumer. There is no combinational path from m_ready to fifo_r_en, and full throughput is sustained at the default depth.

---
 rtl/fifo_pkg.sv | 9 +
 rtl/fifo_out_buf.sv | 62 ++++++
 rtl/fifo_rd_stream.sv | 69 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side drain stage.
package fifo_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;
    localparam int PKT_LEN_DEFAULT    = 4;

    typedef logic [DATA_WIDTH_DEFAULT-1:0] fifo_data_t;

endpackage

// File: rtl/fifo_out_buf.sv
// Small circular buffer holding captured FIFO words until the stream consumer takes them.
module fifo_out_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int BUF_DEPTH  = 3,
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
    localparam int CW = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [CW-1:0]         count
);

    localparam logic [PW-1:0] PTR_LAST = PW'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  pop_ok;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign pop_ok = pop && (count != '0);
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_next(wr_ptr);
            if (pop_ok)
                rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the occupancy count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the FIFO into a local buffer and presents it as a framed valid/ready stream.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int BUF_DEPTH  = 3,
    parameter int PKT_LEN    = PKT_LEN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  flush
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(PKT_LEN - 1);
    localparam logic [CW:0]   ISSUE_MAX = (CW + 1)'(BUF_DEPTH - 1);

    logic [CW-1:0]         occ;
    logic [CW:0]           pending;
    logic                  inflight;
    logic [BW-1:0]         beat_cnt;
    logic [DATA_WIDTH-1:0] head;
    logic                  pop;

    // Reserve a slot for every word already requested, so m_ready never reaches r_en.
    assign pending   = {1'b0, occ} + (CW + 1)'(inflight);
    assign fifo_r_en = rst && !fifo_empty && !flush && (pending <= ISSUE_MAX);

    assign m_valid = (occ != '0);
    assign m_data  = m_valid ? head : '0;
    assign m_last  = m_valid && (beat_cnt == BEAT_LAST);
    assign pop     = m_valid && m_ready && !flush;

    fifo_out_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (inflight && !flush),
        .pop   (pop),
        .din   (fifo_data_out),
        .dout  (head),
        .count (occ)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= 1'b0;
            beat_cnt <= '0;
        end else begin
            inflight <= fifo_r_en;
            if (flush)
                beat_cnt <= '0;
            else if (pop)
                beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + BW'(1);
        end
    end

endmodule
